// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // Sequencer states: stopped, waiting for an idle line, receiving.
    typedef enum logic [1:0] {OFF, ARM, RUN} rx_ctrl_state_t;

    // Bit-level states of the oversampled receiver.
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_bit_state_t;

    localparam int DEFAULT_OVERSAMPLE = 16;
    // Idle bit-times required on the line before reception is armed.
    localparam int IDLE_BITS = 10;

endpackage

// File: rtl/UartRxEn.sv
// Oversampled 8N1 receiver. All state advances only on en, so holding en low
// freezes it. done/err are single-cycle pulses qualified by en.
module UartRxEn
    import uart_pkg::*;
#(
    parameter int Oversample = DEFAULT_OVERSAMPLE
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       en,
    input  logic       line,
    output logic [7:0] data,
    output logic       done,
    output logic       err
);

    localparam int CntWidth = $clog2(Oversample);
    localparam logic [CntWidth-1:0] HalfLast = CntWidth'(Oversample / 2 - 1);
    localparam logic [CntWidth-1:0] BitLast  = CntWidth'(Oversample - 1);
    localparam logic [CntWidth-1:0] CntOne   = CntWidth'(1);

    rx_bit_state_t       state;
    logic [CntWidth-1:0] cnt;
    logic [2:0]          bitIdx;
    logic                sampleStop;

    // Bit sequencer: find start edge, sample each bit at its centre.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state  <= RX_IDLE;
            cnt    <= '0;
            bitIdx <= '0;
            data   <= '0;
        end else if (en) begin
            case (state)
                RX_IDLE: begin
                    if (!line) begin
                        state <= RX_START;
                        cnt   <= '0;
                    end
                end
                RX_START: begin
                    // Half a bit later the start bit must still be low.
                    if (cnt == HalfLast) begin
                        cnt    <= '0;
                        bitIdx <= '0;
                        state  <= line ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                RX_DATA: begin
                    if (cnt == BitLast) begin
                        cnt    <= '0;
                        data   <= {line, data[7:1]};
                        bitIdx <= bitIdx + 3'd1;
                        if (bitIdx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                RX_STOP: begin
                    if (cnt == BitLast) begin
                        cnt   <= '0;
                        state <= line ? RX_IDLE : RX_BREAK;
                    end else begin
                        cnt <= cnt + CntOne;
                    end
                end
                RX_BREAK: begin
                    // After a bad stop bit wait for the line to recover.
                    if (line) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    // Stop-bit sample decides between a good byte and a framing error.
    always_comb begin
        sampleStop = en && (state == RX_STOP) && (cnt == BitLast);
        done       = sampleStop && line;
        err        = sampleStop && !line;
    end

endmodule

// File: rtl/uart_fifo.sv
// Byte FIFO with first-word fall-through read port.
// The caller never pushes while full unless it pops in the same cycle.
module uart_fifo #(
    parameter int Depth = 8
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       push,
    input  logic [7:0] pushData,
    input  logic       pop,
    output logic [7:0] popData,
    output logic       full,
    output logic       empty
);

    localparam int AddrWidth = $clog2(Depth);
    localparam logic [AddrWidth:0] PtrOne = (AddrWidth + 1)'(1);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [AddrWidth:0] wrPtr;
    logic [AddrWidth:0] rdPtr;
    logic [7:0]         mem [Depth];

    // Storage and pointer update; reset clears contents so the head reads 0.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wrPtr[AddrWidth-1:0]] <= pushData;
                wrPtr                     <= wrPtr + PtrOne;
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrOne;
            end
        end
    end

    assign popData = mem[rdPtr[AddrWidth-1:0]];
    assign full    = (wrPtr[AddrWidth] != rdPtr[AddrWidth]) &&
                     (wrPtr[AddrWidth-1:0] == rdPtr[AddrWidth-1:0]);
    assign empty   = (wrPtr == rdPtr);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side sequencer: baud tick generation, line synchroniser, idle-line
// arming, byte FIFO and sticky error status around the UartRxEn receiver.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int Oversample = DEFAULT_OVERSAMPLE,
    parameter int Depth      = 8,
    parameter int DivWidth   = 16
) (
    input  logic                clk,
    input  logic                nReset,
    input  logic                rxEnable,
    input  logic [DivWidth-1:0] divisor,
    input  logic                divLoad,
    input  logic                rxIn,
    output logic [7:0]          outData,
    output logic                outValid,
    input  logic                outReady,
    output logic                overflow,
    output logic                frameErr,
    output logic [7:0]          errCount,
    input  logic                clearStatus,
    output logic                armed
);

    localparam int IdleTarget = IDLE_BITS * Oversample;
    localparam int IdleWidth  = $clog2(IdleTarget + 1);
    localparam logic [IdleWidth-1:0] IdleLast = IdleWidth'(IdleTarget - 1);
    localparam logic [IdleWidth-1:0] IdleOne  = IdleWidth'(1);

    logic                 rxSync1;
    logic                 line;
    logic [DivWidth-1:0]  tickCnt;
    logic [DivWidth-1:0]  reloadVal;
    logic                 tick;
    logic                 leavingRun;
    rx_ctrl_state_t       state;
    logic [IdleWidth-1:0] idleCnt;
    logic                 rxEn;
    logic [7:0]           rxData;
    logic                 rxDone;
    logic                 rxErr;
    logic                 fifoFull;
    logic                 fifoEmpty;
    logic                 fifoPush;
    logic                 fifoPop;
    logic                 ovfEvent;

    // Two-flop synchroniser; resets to the idle-high level.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            rxSync1 <= 1'b1;
            line    <= 1'b1;
        end else begin
            rxSync1 <= rxIn;
            line    <= rxSync1;
        end
    end

    // A divisor of 0 behaves as 1, i.e. a tick every cycle.
    assign reloadVal  = (divisor == '0) ? '0 : divisor - DivWidth'(1);
    assign tick       = (tickCnt == '0);
    assign leavingRun = (state == RUN) && !rxEnable;

    // Down-counter producing one tick every max(divisor,1) cycles.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            tickCnt <= '0;
        end else if (divLoad || leavingRun || tick) begin
            tickCnt <= reloadVal;
        end else begin
            tickCnt <= tickCnt - DivWidth'(1);
        end
    end

    // Sequencer: arm only after IdleTarget consecutive high ticks.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state   <= OFF;
            idleCnt <= '0;
            armed   <= 1'b0;
        end else if (!rxEnable) begin
            state <= OFF;
            armed <= 1'b0;
        end else begin
            case (state)
                OFF: begin
                    state   <= ARM;
                    idleCnt <= '0;
                end
                ARM: begin
                    if (tick) begin
                        if (!line) begin
                            idleCnt <= '0;
                        end else if (idleCnt == IdleLast) begin
                            state <= RUN;
                            armed <= 1'b1;
                        end else begin
                            idleCnt <= idleCnt + IdleOne;
                        end
                    end
                end
                RUN: armed <= 1'b1;
                default: begin
                    state <= OFF;
                    armed <= 1'b0;
                end
            endcase
        end
    end

    assign rxEn = (state == RUN) && rxEnable && tick;

    UartRxEn #(
        .Oversample(Oversample)
    ) uRx (
        .clk   (clk),
        .nReset(nReset),
        .en    (rxEn),
        .line  (line),
        .data  (rxData),
        .done  (rxDone),
        .err   (rxErr)
    );

    // A same-cycle pop frees the slot, so a full FIFO still accepts then.
    assign fifoPop  = outValid && outReady;
    assign fifoPush = rxDone && (!fifoFull || fifoPop);
    assign ovfEvent = rxDone && fifoFull && !fifoPop;
    assign outValid = !fifoEmpty;

    uart_fifo #(
        .Depth(Depth)
    ) uFifo (
        .clk     (clk),
        .nReset  (nReset),
        .push    (fifoPush),
        .pushData(rxData),
        .pop     (fifoPop),
        .popData (outData),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    // Sticky status; a new event takes priority over a coincident clear.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            overflow <= 1'b0;
            frameErr <= 1'b0;
            errCount <= '0;
        end else begin
            if (ovfEvent) begin
                overflow <= 1'b1;
            end else if (clearStatus) begin
                overflow <= 1'b0;
            end

            if (rxErr) begin
                frameErr <= 1'b1;
                if (clearStatus) begin
                    errCount <= 8'd1;
                end else if (errCount != 8'hFF) begin
                    errCount <= errCount + 8'd1;
                end
            end else if (clearStatus) begin
                frameErr <= 1'b0;
                errCount <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: random bytes are framed onto the line,
// expected bytes are queued by a frame-level model, and a monitor compares
// every accepted output byte against the queue head.
module tb_uart_rx_ctrl;

    localparam int OS      = 16;
    localparam int DEPTH   = 8;
    localparam int DW      = 16;
    localparam int DIV     = 3;
    localparam int BIT     = OS * DIV;
    localparam int ARM_CYC = 10 * OS * DIV;

    logic          clk;
    logic          nReset;
    logic          rxEnable;
    logic [DW-1:0] divisor;
    logic          divLoad;
    logic          rxIn;
    logic [7:0]    outData;
    logic          outValid;
    logic          outReady;
    logic          overflow;
    logic          frameErr;
    logic [7:0]    errCount;
    logic          clearStatus;
    logic          armed;

    uart_rx_ctrl #(
        .Oversample(OS),
        .Depth     (DEPTH),
        .DivWidth  (DW)
    ) dut (
        .clk        (clk),
        .nReset     (nReset),
        .rxEnable   (rxEnable),
        .divisor    (divisor),
        .divLoad    (divLoad),
        .rxIn       (rxIn),
        .outData    (outData),
        .outValid   (outValid),
        .outReady   (outReady),
        .overflow   (overflow),
        .frameErr   (frameErr),
        .errCount   (errCount),
        .clearStatus(clearStatus),
        .armed      (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         nRun;
    int         nFail;
    logic [7:0] expQ[$];
    int         readyMode;  // 0 hold low, 1 hold high, 2 random, 3 pop only on done
    bit         discard;
    bit         clearReq;
    bit         clearOnErr;
    bit         ovfExp;
    bit         frameExp;
    int         errExp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nRun++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer-side drivers, updated on the falling edge.
    always @(negedge clk) begin
        case (readyMode)
            0: outReady = 1'b0;
            1: outReady = 1'b1;
            2: outReady = 1'($urandom_range(0, 1));
            default: outReady = dut.rxDone;
        endcase
        clearStatus = clearReq || (clearOnErr && dut.rxErr);
    end

    // Monitor: every accepted byte must match the scoreboard head.
    always @(negedge clk) begin
        #2;
        if (nReset && outValid && outReady && !discard) begin
            if (expQ.size() == 0) begin
                nRun++;
                nFail++;
                $display("FAIL unexpected_byte: got %02h expected none", outData);
            end else begin
                check("fifo_order", 32'(outData), 32'(expQ.pop_front()));
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame one byte at 8N1; the model decides acceptance at stop-bit time.
    task automatic sendByte(input logic [7:0] b, input bit stopBit, input bit popAtDone);
        rxIn = 1'b0;
        waitCycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rxIn = b[i];
            waitCycles(BIT);
        end
        if (stopBit) begin
            if (popAtDone || expQ.size() < DEPTH) expQ.push_back(b);
            else ovfExp = 1'b1;
        end else begin
            frameExp = 1'b1;
            if (clearOnErr) begin
                errExp = 1;
                ovfExp = 1'b0;
            end else if (errExp < 255) begin
                errExp++;
            end
        end
        rxIn = stopBit;
        waitCycles(BIT);
        rxIn = 1'b1;
        waitCycles(BIT / 2);
    endtask

    task automatic sendRand(input int n);
        for (int i = 0; i < n; i++) sendByte(8'($urandom_range(0, 255)), 1'b1, 1'b0);
    endtask

    task automatic clearAll();
        clearReq = 1'b1;
        waitCycles(2);
        clearReq = 1'b0;
        waitCycles(1);
        ovfExp   = 1'b0;
        frameExp = 1'b0;
        errExp   = 0;
    endtask

    task automatic checkStatus(input string tag);
        check({tag, "_overflow"}, 32'(overflow), 32'(ovfExp));
        check({tag, "_frameErr"}, 32'(frameErr), 32'(frameExp));
        check({tag, "_errCount"}, 32'(errCount), 32'(errExp));
    endtask

    task automatic waitArmed(input string tag, input int maxCyc);
        int k = 0;
        while (!armed && k < maxCyc) begin
            waitCycles(1);
            k++;
        end
        check(tag, 32'(armed), 32'd1);
    endtask

    task automatic drain(input string tag);
        int k = 0;
        readyMode = 1;
        while (expQ.size() != 0 && k < 200) begin
            waitCycles(1);
            k++;
        end
        waitCycles(2);
        check({tag, "_queue"}, 32'(expQ.size()), 32'd0);
        check({tag, "_valid"}, 32'(outValid), 32'd0);
        readyMode = 0;
        waitCycles(2);
    endtask

    initial begin
        nRun = 0; nFail = 0;
        readyMode = 0; discard = 0; clearReq = 0; clearOnErr = 0;
        ovfExp = 0; frameExp = 0; errExp = 0;
        nReset = 1'b0; rxEnable = 1'b0; divisor = DW'(DIV); divLoad = 1'b0; rxIn = 1'b1;
        outReady = 1'b0; clearStatus = 1'b0;
        waitCycles(3);
        check("rst_outData", 32'(outData), 32'd0);
        check("rst_outValid", 32'(outValid), 32'd0);
        checkStatus("rst");
        check("rst_armed", 32'(armed), 32'd0);
        @(negedge clk) nReset = 1'b1;
        waitCycles(1);
        divLoad = 1'b1;
        waitCycles(1);
        divLoad = 1'b0;

        // 1: arm on idle line, then a known byte and a few random ones.
        rxEnable = 1'b1;
        waitCycles(ARM_CYC - 40);
        check("armed_early", 32'(armed), 32'd0);
        waitArmed("armed_rise", 200);
        sendByte(8'hA5, 1'b1, 1'b0);
        check("a5_valid", 32'(outValid), 32'd1);
        check("a5_data", 32'(outData), 32'hA5);
        checkStatus("a5");
        readyMode = 2;
        sendRand(4);
        drain("t1");

        // 2: overflow with the consumer stalled.
        sendRand(DEPTH + 1);
        checkStatus("ovf");
        check("ovf_head", 32'(outData), 32'(expQ[0]));
        clearAll();
        checkStatus("ovf_clr");

        // 3: full FIFO, pop coincides with done.
        readyMode = 3;
        sendByte(8'($urandom_range(0, 255)), 1'b1, 1'b1);
        readyMode = 0;
        waitCycles(2);
        checkStatus("popdone");
        check("popdone_valid", 32'(outValid), 32'd1);
        drain("t3");

        // 4: framing errors, then clear coinciding with an err.
        readyMode = 1;
        sendByte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        checkStatus("ferr1");
        sendByte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        checkStatus("ferr2");
        clearOnErr = 1'b1;
        sendByte(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        clearOnErr = 1'b0;
        checkStatus("ferr_clr");
        sendRand(1);
        drain("t4");

        // 5: line low blocks arming; disable mid-byte keeps the FIFO.
        rxEnable = 1'b0;
        waitCycles(2);
        check("off_armed", 32'(armed), 32'd0);
        rxIn = 1'b0;
        rxEnable = 1'b1;
        waitCycles(ARM_CYC + 100);
        check("lowline_armed", 32'(armed), 32'd0);
        rxIn = 1'b1;
        waitCycles(ARM_CYC - 40);
        check("relax_armed", 32'(armed), 32'd0);
        waitArmed("rearm", 200);
        sendRand(3);
        rxIn = 1'b0;
        waitCycles(BIT * 3);
        rxEnable = 1'b0;
        waitCycles(1);
        check("dis_armed", 32'(armed), 32'd0);
        rxIn = 1'b1;
        waitCycles(300);
        check("dis_valid", 32'(outValid), 32'd1);
        check("dis_head", 32'(outData), 32'(expQ[0]));
        drain("t5");

        // Resume; the frozen partial frame may yield a junk byte, flushed unchecked.
        rxEnable = 1'b1;
        waitArmed("rearm2", ARM_CYC + 200);
        waitCycles(BIT * 11);
        discard = 1'b1;
        readyMode = 1;
        waitCycles(20);
        readyMode = 0;
        waitCycles(3);
        discard = 1'b0;
        clearAll();

        // 6: reset mid-byte with bytes buffered.
        sendRand(3);
        rxIn = 1'b0;
        waitCycles(BIT * 3);
        nReset = 1'b0;
        #1;
        check("rst2_outValid", 32'(outValid), 32'd0);
        check("rst2_outData", 32'(outData), 32'd0);
        check("rst2_armed", 32'(armed), 32'd0);
        expQ.delete();
        ovfExp = 0; frameExp = 0; errExp = 0;
        checkStatus("rst2");
        rxIn = 1'b1;
        waitCycles(5);
        @(negedge clk) nReset = 1'b1;
        waitArmed("post_rst_arm", ARM_CYC + 200);
        sendRand(2);
        checkStatus("post_rst");
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", nRun, nFail);
        $finish;
    end

endmodule
